spi_master_engine: RTL and testbench

//  Synthesizable, parametrised SPI master. It replaces the behavioural sclk/ss/mosi

---
 rtl/spi_master_engine.sv | 149 ++++++++++++++
 tb/tb_spi_master_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_engine.sv
// SPI master: programmable frame width, sclk divider, CPOL/CPHA mode and ss guard times,
// with a start/busy/done handshake toward the host register logic.
module spi_master_engine #(
  parameter int DATA_W   = 16,
  parameter int CLKDIV   = 4,
  parameter int CPOL     = 1,
  parameter int CPHA     = 1,
  parameter int SS_SETUP = 2,
  parameter int SS_HOLD  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] txdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rxdata,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  // state | meaning
  // IDLE  | waiting for start; ss low, sclk at CPOL
  // SETUP | ss asserted, guard time before the first sclk edge
  // XFER  | 2*DATA_W sclk edges, shifting mosi out and miso in
  // HOLD  | guard time after the last sclk edge, ss still asserted
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam int DIV_W  = $clog2(CLKDIV + 1);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam int GD_MAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int GD_W   = $clog2(GD_MAX + 1);

  localparam logic [DIV_W-1:0]  DIV_TC    = DIV_W'(CLKDIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
  localparam logic [GD_W-1:0]   SETUP_LD  = GD_W'(SS_SETUP - 1);
  localparam logic [GD_W-1:0]   HOLD_LD   = GD_W'(SS_HOLD - 1);
  localparam logic              SCLK_IDLE = 1'(CPOL);

  logic [1:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [GD_W-1:0]   gd_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;

  logic div_tc;
  logic last_edge;
  logic lead_edge;
  logic sample_edge;
  logic launch_edge;

  // edge_cnt holds the number of edges already made, so an even count means a leading edge
  assign div_tc      = (div_cnt == DIV_TC);
  assign last_edge   = (edge_cnt == EDGE_LAST);
  assign lead_edge   = ~edge_cnt[0];
  assign sample_edge = (CPHA == 0) ? lead_edge : ~lead_edge;
  assign launch_edge = (CPHA == 0) ? (~lead_edge & ~last_edge) : lead_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      gd_cnt   <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rxdata   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= SCLK_IDLE;
      ss       <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= SCLK_IDLE;
          if (start) begin
            state  <= SETUP;
            busy   <= 1'b1;
            ss     <= 1'b1;
            gd_cnt <= SETUP_LD;
            rx_sh  <= '0;
            // CPHA=0 presents the MSB before the first edge, so it leaves the shifter now
            if (CPHA == 0) begin
              tx_sh <= {txdata[DATA_W-2:0], 1'b0};
              mosi  <= txdata[DATA_W-1];
            end else begin
              tx_sh <= txdata;
              mosi  <= 1'b0;
            end
          end
        end
        SETUP: begin
          if (gd_cnt == '0) begin
            state    <= XFER;
            div_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            gd_cnt <= gd_cnt - 1'b1;
          end
        end
        XFER: begin
          if (div_tc) begin
            div_cnt  <= '0;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 1'b1;
            if (sample_edge) begin
              rx_sh <= {rx_sh[DATA_W-2:0], miso};
            end
            if (launch_edge) begin
              mosi  <= tx_sh[DATA_W-1];
              tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
            end
            if (last_edge) begin
              state  <= HOLD;
              gd_cnt <= HOLD_LD;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          sclk <= SCLK_IDLE;
          if (gd_cnt == '0) begin
            state  <= IDLE;
            ss     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            rxdata <= rx_sh;
            mosi   <= 1'b0;
          end else begin
            gd_cnt <= gd_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: five parameter variants checked against frame-level
// expectations (received word, frame length, sclk edge count, mosi bit order).
module tb_spi_master_engine;

  localparam int N_DEF = 2 + 2 * 16 * 4 + 2;
  localparam int N_NAR = 1 + 2 * 8 * 1 + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  start_v = '0;
  logic [15:0] txdata = '0;
  logic [15:0] rsp1 = '0;

  logic        busy0, done0, sclk0, ss0, mosi0, miso0;
  logic        busy1, done1, sclk1, ss1, mosi1, miso1;
  logic        busy2, done2, sclk2, ss2, mosi2, miso2;
  logic        busy3, done3, sclk3, ss3, mosi3, miso3;
  logic        busy4, done4, sclk4, ss4, mosi4, miso4;
  logic [15:0] rx0, rx1, rx3, rx4;
  logic [7:0]  rx2;

  logic [4:0] busy_w, done_w, sclk_w, ss_w, mosi_w;
  assign busy_w = {busy4, busy3, busy2, busy1, busy0};
  assign done_w = {done4, done3, done2, done1, done0};
  assign sclk_w = {sclk4, sclk3, sclk2, sclk1, sclk0};
  assign ss_w   = {ss4, ss3, ss2, ss1, ss0};
  assign mosi_w = {mosi4, mosi3, mosi2, mosi1, mosi0};

  int          n_cmp = 0;
  int          n_mis = 0;
  int          rcnt[5];
  logic [15:0] cap[5];
  logic [4:0]  sq = '0;

  // observer: counts rising sclk edges inside each frame and records mosi at them
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (!ss_w[i]) begin
        rcnt[i] = 0;
        cap[i]  = '0;
      end else if (sclk_w[i] && !sq[i]) begin
        rcnt[i] = rcnt[i] + 1;
        cap[i]  = {cap[i][14:0], mosi_w[i]};
      end
      sq[i] = sclk_w[i];
    end
  end

  assign miso0 = mosi0;
  assign miso1 = (rcnt[1] < 16) ? rsp1[15 - rcnt[1]] : 1'b0;
  assign miso2 = 1'b1;
  assign miso3 = mosi3;
  assign miso4 = mosi4;

  always #5 clk = ~clk;

  spi_master_engine u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .txdata(txdata), .busy(busy0), .done(done0),
    .rxdata(rx0), .sclk(sclk0), .ss(ss0), .mosi(mosi0), .miso(miso0));

  spi_master_engine #(.CPOL(0), .CPHA(0)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .txdata(txdata), .busy(busy1), .done(done1),
    .rxdata(rx1), .sclk(sclk1), .ss(ss1), .mosi(mosi1), .miso(miso1));

  spi_master_engine #(.DATA_W(8), .CLKDIV(1), .SS_SETUP(1), .SS_HOLD(1)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .txdata(txdata[7:0]), .busy(busy2),
    .done(done2), .rxdata(rx2), .sclk(sclk2), .ss(ss2), .mosi(mosi2), .miso(miso2));

  spi_master_engine #(.CPOL(1), .CPHA(0)) u3 (
    .clk(clk), .reset(reset), .start(start_v[3]), .txdata(txdata), .busy(busy3), .done(done3),
    .rxdata(rx3), .sclk(sclk3), .ss(ss3), .mosi(mosi3), .miso(miso3));

  spi_master_engine #(.CPOL(0), .CPHA(1)) u4 (
    .clk(clk), .reset(reset), .start(start_v[4]), .txdata(txdata), .busy(busy4), .done(done4),
    .rxdata(rx4), .sclk(sclk4), .ss(ss4), .mosi(mosi4), .miso(miso4));

  function automatic logic [15:0] rx_of(input int idx);
    case (idx)
      0:       return rx0;
      1:       return rx1;
      2:       return {8'h00, rx2};
      3:       return rx3;
      default: return rx4;
    endcase
  endfunction

  int          t_cyc;
  int          t_busy;
  int          t_rise;
  logic [15:0] t_rx;
  logic [15:0] t_cap;
  logic        t_mosi_first;

  // one frame on instance idx; txdata is scrambled right after acceptance
  task automatic run_frame(input int idx, input logic [15:0] tx);
    @(negedge clk);
    txdata = tx;
    start_v[idx] = 1'b1;
    @(posedge clk);
    #1;
    start_v[idx] = 1'b0;
    txdata = 16'($urandom);
    t_mosi_first = mosi_w[idx];
    t_cyc = 0;
    t_busy = busy_w[idx] ? 1 : 0;
    while (!done_w[idx] && t_cyc < 1000) begin
      @(posedge clk);
      #1;
      t_cyc++;
      if (busy_w[idx]) t_busy++;
    end
    t_rx   = rx_of(idx);
    t_rise = rcnt[idx];
    t_cap  = cap[idx];
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({sclk0, ss0, mosi0, busy0, done0} !== 5'b10000) begin
      n_mis++;
      $display("FAIL reset_u0_ctrl: got %b want 10000", {sclk0, ss0, mosi0, busy0, done0});
    end
    n_cmp++;
    if ({sclk1, ss1, mosi1, busy1, done1} !== 5'b00000) begin
      n_mis++;
      $display("FAIL reset_u1_ctrl: got %b want 00000", {sclk1, ss1, mosi1, busy1, done1});
    end
    n_cmp++;
    if ({rx0, rx1, rx2} !== 40'h0) begin
      n_mis++;
      $display("FAIL reset_rxdata: got %h want 0", {rx0, rx1, rx2});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mode3_loopback();
    logic [15:0] tx;
    for (int k = 0; k < 4; k++) begin
      tx = (k == 0) ? 16'h55AA : 16'($urandom);
      run_frame(0, tx);
      n_cmp++;
      if (t_cyc !== N_DEF) begin
        n_mis++;
        $display("FAIL m3_latency: got %0d want %0d", t_cyc, N_DEF);
      end
      n_cmp++;
      if (t_rx !== tx) begin
        n_mis++;
        $display("FAIL m3_rxdata: got %h want %h", t_rx, tx);
      end
      n_cmp++;
      if (t_rise !== 16 || t_cap !== tx) begin
        n_mis++;
        $display("FAIL m3_sclk_mosi: got rises %0d bits %h want 16 %h", t_rise, t_cap, tx);
      end
      n_cmp++;
      if (t_busy !== N_DEF) begin
        n_mis++;
        $display("FAIL m3_busy_len: got %0d want %0d", t_busy, N_DEF);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({done0, sclk0, ss0, mosi0, rx0} !== {4'b0100, tx}) begin
        n_mis++;
        $display("FAIL m3_after_done: got %b %h want 0100 %h", {done0, sclk0, ss0, mosi0}, rx0, tx);
      end
    end
  endtask

  task automatic test_mode0_slave();
    logic [15:0] tx;
    for (int k = 0; k < 3; k++) begin
      rsp1 = (k == 0) ? 16'h8001 : 16'($urandom);
      tx = 16'($urandom);
      run_frame(1, tx);
      n_cmp++;
      if (t_mosi_first !== tx[15]) begin
        n_mis++;
        $display("FAIL m0_mosi_msb: got %b want %b", t_mosi_first, tx[15]);
      end
      n_cmp++;
      if (t_rx !== rsp1 || t_cyc !== N_DEF) begin
        n_mis++;
        $display("FAIL m0_rxdata: got %h at %0d want %h at %0d", t_rx, t_cyc, rsp1, N_DEF);
      end
      n_cmp++;
      if (t_rise !== 16 || t_cap !== tx) begin
        n_mis++;
        $display("FAIL m0_mosi_bits: got rises %0d bits %h want 16 %h", t_rise, t_cap, tx);
      end
      n_cmp++;
      if (sclk1 !== 1'b0) begin
        n_mis++;
        $display("FAIL m0_sclk_idle: got %b want 0", sclk1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] tx1, tx2;
    int cyc;
    tx1 = 16'($urandom);
    tx2 = 16'($urandom);
    @(negedge clk);
    txdata = tx1;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    txdata = 16'($urandom);
    cyc = 0;
    while (!done0 && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++;
    if (cyc !== N_DEF || rx0 !== tx1 || ss0 !== 1'b0) begin
      n_mis++;
      $display("FAIL b2b_first: got %0d %h ss %b want %0d %h ss 0", cyc, rx0, ss0, N_DEF, tx1);
    end
    txdata = tx2;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({ss0, busy0, done0} !== 3'b110) begin
      n_mis++;
      $display("FAIL b2b_restart: got %b want 110", {ss0, busy0, done0});
    end
    start_v[0] = 1'b0;
    txdata = 16'($urandom);
    cyc = 0;
    while (!done0 && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      start_v[0] = (cyc == 50);
    end
    start_v[0] = 1'b0;
    n_cmp++;
    if (cyc !== N_DEF || rx0 !== tx2) begin
      n_mis++;
      $display("FAIL b2b_second: got %0d %h want %0d %h", cyc, rx0, N_DEF, tx2);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy0, ss0} !== 2'b00) begin
      n_mis++;
      $display("FAIL b2b_no_queue: got %b want 00", {busy0, ss0});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] tx;
    int dcnt;
    tx = 16'($urandom);
    @(negedge clk);
    txdata = tx;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (2 + 9 * 4) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy0, sclk0} !== 2'b10) begin
      n_mis++;
      $display("FAIL rst_mid_pre: got %b want 10", {busy0, sclk0});
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({ss0, sclk0, busy0, mosi0, done0} !== 5'b01000) begin
      n_mis++;
      $display("FAIL rst_mid_async: got %b want 01000", {ss0, sclk0, busy0, mosi0, done0});
    end
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (N_DEF + 10) begin
      @(posedge clk);
      #1;
      if (done0) dcnt++;
    end
    n_cmp++;
    if (dcnt !== 0 || rx0 !== 16'h0) begin
      n_mis++;
      $display("FAIL rst_mid_nodone: got %0d pulses rx %h want 0 pulses rx 0000", dcnt, rx0);
    end
    run_frame(0, tx);
    n_cmp++;
    if (t_cyc !== N_DEF || t_rx !== tx || t_rise !== 16) begin
      n_mis++;
      $display("FAIL rst_mid_clean: got %0d %h %0d want %0d %h 16", t_cyc, t_rx, t_rise, N_DEF, tx);
    end
  endtask

  task automatic test_narrow();
    logic [15:0] tx;
    for (int k = 0; k < 2; k++) begin
      tx = 16'($urandom);
      run_frame(2, tx);
      n_cmp++;
      if (t_rx !== 16'h00FF) begin
        n_mis++;
        $display("FAIL nar_rxdata: got %h want 00ff", t_rx);
      end
      n_cmp++;
      if (t_cyc !== N_NAR || t_busy !== N_NAR) begin
        n_mis++;
        $display("FAIL nar_timing: got %0d busy %0d want %0d", t_cyc, t_busy, N_NAR);
      end
      n_cmp++;
      if (t_rise !== 8 || t_cap[7:0] !== tx[7:0]) begin
        n_mis++;
        $display("FAIL nar_sclk_mosi: got %0d %h want 8 %h", t_rise, t_cap[7:0], tx[7:0]);
      end
    end
  endtask

  task automatic test_modes();
    logic [15:0] tx;
    for (int m = 3; m < 5; m++) begin
      for (int k = 0; k < 2; k++) begin
        tx = (k == 0) ? 16'hA5C3 : 16'($urandom);
        run_frame(m, tx);
        n_cmp++;
        if (t_rx !== tx || t_cyc !== N_DEF) begin
          n_mis++;
          $display("FAIL mode_u%0d_loop: got %h at %0d want %h at %0d", m, t_rx, t_cyc, tx, N_DEF);
        end
        n_cmp++;
        if (t_rise !== 16 || sclk_w[m] !== ((m == 3) ? 1'b1 : 1'b0)) begin
          n_mis++;
          $display("FAIL mode_u%0d_sclk: got rises %0d idle %b", m, t_rise, sclk_w[m]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode3_loopback();
    test_mode0_slave();
    test_back_to_back();
    test_reset_mid_frame();
    test_narrow();
    test_modes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
